instr_fetch_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage types: machine width, fetch FSM states and buffer entry layout.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush overrides push and pop.
module fetch_buffer
  import rv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop && !flush && !empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    do_push = push && !flush && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, buffered instructions to decode, next_pc selection.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic [CW-1:0]   buf_count;
  logic            buf_empty;
  logic            buf_full_unused;
  fetch_entry_t    buf_head;
  fetch_entry_t    push_entry;
  logic            push, pop, accept, outstanding;
  logic [CW:0]     occupancy;

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (buf_count),
    .empty      (buf_empty),
    .full       (buf_full_unused),
    .head       (buf_head)
  );

  always_comb begin
    outstanding    = (state_q == WAIT) || (state_q == DROP);
    // A request is only issued if its response is guaranteed a buffer slot.
    occupancy      = {1'b0, buf_count} + {{CW{1'b0}}, outstanding};
    imem_req_valid = !reset && (state_q == REQ) && (occupancy < (CW+1)'(DEPTH));
    imem_req_addr  = pc;
    accept         = imem_req_valid && imem_req_ready;

    state_d    = state_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    push_entry = '{pc: req_pc_q, inst: imem_resp_data};

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (accept) begin
          req_pc_d = pc;
          state_d  = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          push    = !redirect_valid;
          state_d = REQ;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    inst_valid = !reset && !buf_empty;
    pop        = inst_valid && inst_ready;
    inst_data  = buf_empty ? '0 : buf_head.inst;
    inst_pc    = buf_empty ? '0 : buf_head.pc;

    if (reset)               next_pc = RESET_PC;
    else if (redirect_valid) next_pc = align_word(redirect_target);
    else if (accept)         next_pc = pc + XLEN'(INST_BYTES);
    else                     next_pc = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: acts as PC register and instruction memory, checks the decode stream.
module tb_instr_fetch_unit;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] epc;
    logic [31:0] edata;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          lat = 1;
  bit          lat_rnd = 1'b0;
  bit          follow = 1'b1;
  logic [31:0] exp_pc = 32'h0;
  mreq_t       mq[$];
  obs_t        obs_q[$];

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .next_pc         (next_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Program image: word at address a is "addi x(n%32), x0, n" with n = a/4.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    logic [31:0] n;
    n = a >> 2;
    return (n << 20) | ((n & 32'd31) << 7) | 32'h13;
  endfunction

  // One clock: record decode handshakes against the in-order program model, advance the PC
  // register, and play the instruction memory (one response per accepted request).
  task automatic tick();
    logic [31:0] npc, aaddr;
    logic        acc;
    int          k, due;
    obs_t        o;
    mreq_t       m;
    npc   = next_pc;
    acc   = imem_req_valid && imem_req_ready;
    aaddr = imem_req_addr;
    if (inst_valid && inst_ready) begin
      o.pc = inst_pc; o.data = inst_data; o.epc = exp_pc; o.edata = inst_of(exp_pc);
      obs_q.push_back(o);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid && !reset) exp_pc = redirect_target & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    cyc++;
    if (follow) pc = npc;
    if (imem_resp_valid && mq.size() > 0) m = mq.pop_front();
    if (acc) begin
      k   = lat_rnd ? $urandom_range(3, 1) : lat;
      due = cyc - 1 + k;
      if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
      m.due = due; m.addr = aaddr;
      mq.push_back(m);
      n_acc++;
    end
    imem_resp_valid = (mq.size() > 0) && (mq[0].due == cyc);
    imem_resp_data  = imem_resp_valid ? inst_of(mq[0].addr) : $urandom;
    redirect_valid  = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    follow = 1'b1; reset = 1'b1; redirect_valid = 1'b0; lat_rnd = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    obs_q.delete();
    imem_resp_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    follow = 1'b0; pc = 32'h40; reset = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (next_pc !== 32'h0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: cycle %0d next_pc=%h req_valid=%b inst_valid=%b, required 00000000/0/0",
                 i, next_pc, imem_req_valid, inst_valid);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_cycle: req_valid=%b, required 0", imem_req_valid);
    end
    tick();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL reset_first_req: req_valid=%b addr=%h, required 1/00000040", imem_req_valid, imem_req_addr);
    end
    n_tests++;
    if (next_pc !== 32'h40 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: next_pc=%h inst_valid=%b, required 00000040/0", next_pc, inst_valid);
    end
  endtask

  task automatic test_straight();
    logic [31:0] exp_addr, rpc;
    bit          had_resp;
    int          got;
    obs_t        o;
    apply_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1; exp_pc = 32'h0;
    exp_addr = 32'h0; had_resp = 1'b0; rpc = 32'h0; got = 0;
    #1;
    for (int i = 0; i < 14; i++) begin
      if (had_resp) begin
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== rpc || inst_data !== inst_of(rpc)) begin
          n_fail++;
          $display("FAIL straight_latency: inst_valid=%b pc=%h data=%h, required 1/%h/%h",
                   inst_valid, inst_pc, inst_data, rpc, inst_of(rpc));
        end
      end
      if (imem_resp_valid) begin
        n_tests++;
        if (inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL straight_no_bypass: inst_valid=%b during response, required 0", inst_valid);
        end
      end
      if (imem_req_valid) begin
        n_tests++;
        if (imem_req_addr !== exp_addr || next_pc !== pc + 32'd4) begin
          n_fail++;
          $display("FAIL straight_req: addr=%h next_pc=%h, required %h/%h",
                   imem_req_addr, next_pc, exp_addr, pc + 32'd4);
        end
        exp_addr = exp_addr + 32'd4;
      end
      had_resp = imem_resp_valid;
      rpc      = (imem_resp_valid && mq.size() > 0) ? mq[0].addr : 32'h0;
      tick();
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); got++; n_tests++;
      if (o.pc !== o.epc || o.data !== o.edata) begin
        n_fail++;
        $display("FAIL straight_stream: pc=%h inst=%h, required %h/%h", o.pc, o.data, o.epc, o.edata);
      end
    end
    n_tests++;
    if (got < 5) begin
      n_fail++;
      $display("FAIL straight_count: delivered %0d, required at least 5", got);
    end
  endtask

  task automatic test_backpressure();
    int   a0, got;
    obs_t o;
    apply_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; lat = 1; exp_pc = 32'h0; a0 = n_acc; got = 0;
    for (int i = 0; i < 12; i++) tick();
    n_tests++;
    if (imem_req_valid !== 1'b0 || next_pc !== pc || (n_acc - a0) !== 2) begin
      n_fail++;
      $display("FAIL bp_stall: req_valid=%b next_pc=%h accepts=%0d, required 0/%h/2",
               imem_req_valid, next_pc, n_acc - a0, pc);
    end
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b pc=%h data=%h, required 1/00000000/00000013", inst_valid, inst_pc, inst_data);
    end
    inst_ready = 1'b1;
    #1;
    for (int i = 0; i < 24; i++) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); got++; n_tests++;
      if (o.pc !== o.epc || o.data !== o.edata) begin
        n_fail++;
        $display("FAIL bp_stream: pc=%h inst=%h, required %h/%h", o.pc, o.data, o.epc, o.edata);
      end
    end
    n_tests++;
    if (got < 8) begin
      n_fail++;
      $display("FAIL bp_count: delivered %0d, required at least 8", got);
    end
  endtask

  task automatic test_redirect_wait();
    int   a0, got, i;
    obs_t o;
    apply_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; lat = 3; exp_pc = 32'h0; a0 = n_acc; got = 0;
    for (i = 0; i < 30 && n_acc < a0 + 2; i++) tick();
    n_tests++;
    if (n_acc < a0 + 2) begin
      n_fail++;
      $display("FAIL rw_timeout: accepts=%0d, required 2", n_acc - a0);
    end
    redirect_valid = 1'b1; redirect_target = 32'h1003;
    #1;
    n_tests++;
    if (next_pc !== 32'h1000 || inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_next_pc: next_pc=%h inst_valid=%b, required 00001000/1", next_pc, inst_valid);
    end
    tick();
    n_tests++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_flush: inst_valid=%b req_valid=%b, required 0/0", inst_valid, imem_req_valid);
    end
    inst_ready = 1'b1;
    #1;
    for (i = 0; i < 10 && !imem_req_valid; i++) tick();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL rw_next_req: req_valid=%b addr=%h, required 1/00001000", imem_req_valid, imem_req_addr);
    end
    for (i = 0; i < 12; i++) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); got++; n_tests++;
      if (o.pc !== o.epc || o.data !== o.edata) begin
        n_fail++;
        $display("FAIL rw_stream: pc=%h inst=%h, required %h/%h", o.pc, o.data, o.epc, o.edata);
      end
    end
    n_tests++;
    if (got < 1) begin
      n_fail++;
      $display("FAIL rw_count: delivered %0d, required at least 1", got);
    end
  endtask

  task automatic test_redirect_accept();
    int   got, i;
    obs_t o;
    apply_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 2; exp_pc = 32'h0; got = 0;
    #1;
    for (i = 0; i < 80 && !(imem_req_valid && pc == 32'h20); i++) tick();
    redirect_valid = 1'b1; redirect_target = 32'h200;
    #1;
    n_tests++;
    if (next_pc !== 32'h200 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL ra_accept: next_pc=%h req_valid=%b addr=%h, required 00000200/1/00000020",
               next_pc, imem_req_valid, imem_req_addr);
    end
    tick();
    n_tests++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ra_drop: req_valid=%b inst_valid=%b, required 0/0", imem_req_valid, inst_valid);
    end
    for (i = 0; i < 10 && !imem_req_valid; i++) tick();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL ra_next_req: req_valid=%b addr=%h, required 1/00000200", imem_req_valid, imem_req_addr);
    end
    for (i = 0; i < 10; i++) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); got++; n_tests++;
      if (o.pc !== o.epc || o.data !== o.edata) begin
        n_fail++;
        $display("FAIL ra_stream: pc=%h inst=%h, required %h/%h", o.pc, o.data, o.epc, o.edata);
      end
    end
    n_tests++;
    if (got < 9) begin
      n_fail++;
      $display("FAIL ra_count: delivered %0d, required at least 9", got);
    end
  endtask

  task automatic test_wrap_reset();
    int   got, bad;
    obs_t o;
    apply_reset();
    follow = 1'b0; pc = 32'hFFFF_FFFC; imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 3;
    exp_pc = 32'hFFFF_FFFC; got = 0; bad = 0;
    #1;
    tick();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC || next_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next_pc: req_valid=%b addr=%h next_pc=%h, required 1/fffffffc/00000000",
               imem_req_valid, imem_req_addr, next_pc);
    end
    follow = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (next_pc !== 32'h0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_reset_outputs: next_pc=%h req_valid=%b inst_valid=%b, required 00000000/0/0",
               next_pc, imem_req_valid, inst_valid);
    end
    tick();
    tick();
    reset = 1'b0; imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (inst_valid !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wait_reset_stale: inst_valid high on %0d cycles after reset, required 0", bad);
    end
    exp_pc = pc; imem_req_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); got++; n_tests++;
      if (o.pc !== o.epc || o.data !== o.edata) begin
        n_fail++;
        $display("FAIL wait_reset_stream: pc=%h inst=%h, required %h/%h", o.pc, o.data, o.epc, o.edata);
      end
    end
    n_tests++;
    if (got < 1) begin
      n_fail++;
      $display("FAIL wait_reset_count: delivered %0d, required at least 1", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] enp;
    int          got;
    obs_t        o;
    apply_reset();
    exp_pc = 32'h0; lat_rnd = 1'b1; got = 0;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      #1;
      if (redirect_valid)                        enp = redirect_target & 32'hFFFF_FFFC;
      else if (imem_req_valid && imem_req_ready) enp = pc + 32'd4;
      else                                       enp = pc;
      n_tests++;
      if (next_pc !== enp) begin
        n_fail++;
        $display("FAIL rnd_next_pc: cycle %0d next_pc=%h, required %h", cyc, next_pc, enp);
      end
      if (imem_req_valid) begin
        n_tests++;
        if (imem_req_addr !== pc || mq.size() != 0) begin
          n_fail++;
          $display("FAIL rnd_req: cycle %0d addr=%h outstanding=%0d, required %h/0", cyc, imem_req_addr, mq.size(), pc);
        end
      end
      tick();
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front(); got++; n_tests++;
        if (o.pc !== o.epc || o.data !== o.edata) begin
          n_fail++;
          $display("FAIL rnd_stream: cycle %0d pc=%h inst=%h, required %h/%h", cyc, o.pc, o.data, o.epc, o.edata);
        end
      end
    end
    redirect_valid = 1'b0;
    n_tests++;
    if (got < 100) begin
      n_fail++;
      $display("FAIL rnd_count: delivered %0d, required at least 100", got);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
